// File: rtl/mapped_mem_bank.sv
// Base-mapped word memory with a valid/ready request port and a fixed-latency response pipeline.
// Optional per-byte write masking is enabled by defining MEM_BYTE_MASK_EN.
module mapped_mem_bank #(
    parameter int BITS       = 32,
    parameter int WORD_DEPTH = 1024,
    parameter int LATENCY    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       base,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [BITS-1:0]   req_wdata,
    input  logic [BITS/8-1:0] req_wstrb,
    output logic              resp_valid,
    output logic [BITS-1:0]   resp_rdata,
    output logic              resp_err
);

    // state | meaning
    // INIT  | after reset: not ready, sampling base
    // RUN   | accepting one request per cycle
    typedef enum logic {INIT, RUN} state_t;

    localparam int          IDX_W   = $clog2(WORD_DEPTH);
    localparam logic [29:0] DEPTH30 = 30'(WORD_DEPTH);

    state_t            state_q, state_d;
    logic [31:0]       base_reg;
    logic [BITS-1:0]   mem [WORD_DEPTH];
    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [BITS-1:0]   pipe_rdata [LATENCY];
    logic [31:0]       off;
    logic              hit;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [BITS-1:0]   wr_word;
    logic              unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            base_reg <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) base_reg <= base;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            INIT:    state_d = RUN;
            RUN:     req_ready = 1'b1;
            default: state_d = INIT;
        endcase
    end

    // Wrapping subtraction; the explicit >= check rejects addresses below base.
    assign off    = req_addr - base_reg;
    assign hit    = (req_addr[1:0] == 2'b00) && (req_addr >= base_reg) && (off[31:2] < DEPTH30);
    assign idx    = off[IDX_W+1:2];
    assign accept = req_valid && req_ready;

    always_comb begin
        wr_word = mem[idx];
`ifdef MEM_BYTE_MASK_EN
        for (int k = 0; k < BITS/8; k++) begin
            if (req_wstrb[k]) wr_word[8*k +: 8] = req_wdata[8*k +: 8];
        end
`else
        wr_word = req_wdata;
`endif
    end

`ifdef MEM_BYTE_MASK_EN
    assign unused_bits = ^off[1:0];
`else
    assign unused_bits = ^{off[1:0], req_wstrb};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORD_DEPTH; i++) mem[i] <= '0;
        end else if (accept && req_wen && hit) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_rdata[i] <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !hit;
            pipe_rdata[0] <= (accept && hit && !req_wen) ? mem[idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
        end
    end

    assign resp_valid = pipe_valid[LATENCY-1];
    assign resp_err   = pipe_err[LATENCY-1];
    assign resp_rdata = pipe_rdata[LATENCY-1];

endmodule

// File: tb/tb_mapped_mem_bank.sv
// Bench for mapped_mem_bank: byte-addressed reference memory, timestamped expected/observed response queues.
module tb_mapped_mem_bank;

    localparam int BITS  = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;
`ifdef MEM_BYTE_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]     c;
        logic [BITS-1:0] d;
        logic            e;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       base = 32'h0000_1000;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wen = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [BITS-1:0]   req_wdata = '0;
    logic [BITS/8-1:0] req_wstrb = '0;
    logic              resp_valid;
    logic [BITS-1:0]   resp_rdata;
    logic              resp_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_base = 32'h0000_1000;
    logic [7:0]  ref_mem [int unsigned];
    resp_t       exp_q[$];
    resp_t       obs_q[$];

    mapped_mem_bank #(.BITS(BITS), .WORD_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .base(base),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) obs_q.push_back('{c: 32'(cyc), d: resp_rdata, e: resp_err});
    end

    // Drives one request for one cycle and records what the memory should answer, and when.
    task automatic send(input logic wen, input logic [31:0] addr,
                        input logic [BITS-1:0] wd, input logic [BITS/8-1:0] st);
        resp_t r;
        logic  hit;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = st;
        hit = (addr % 4 == 0) && (64'(addr) >= 64'(m_base)) && (64'(addr) < 64'(m_base) + 64'(4*DEPTH));
        r.c = 32'(cyc + LAT);
        r.d = '0;
        r.e = !hit;
        if (hit) begin
            for (int k = 0; k < BITS/8; k++) begin
                if (!wen) r.d[8*k +: 8] = ref_mem.exists(addr + k) ? ref_mem[addr + k] : 8'h00;
                else if (!MASK || st[k]) ref_mem[addr + k] = wd[8*k +: 8];
            end
        end
        exp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, expected all 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        rst_n = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h1000;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: got %b, expected 0", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge: got %b, expected 1", req_ready);
        end
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL init_no_resp: got %0d responses, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_write_read;
        send(1'b1, 32'h1004, 32'hDEAD_BEEF, 4'hF);
        send(1'b0, 32'h1004, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL wr_rd_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wr_rd_resp[%0d]: got c=%0d d=%h e=%b, expected c=%0d d=%h e=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].e, exp_q[i].c, exp_q[i].d, exp_q[i].e);
            end
        end
        checks++;
        if (obs_q.size() < 2 || obs_q[1].d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_rd_data: got %h, expected deadbeef", obs_q.size() >= 2 ? obs_q[1].d : 'x);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_errors;
        send(1'b0, 32'h0FFC, '0, '0);
        send(1'b0, 32'h1002, '0, '0);
        send(1'b0, m_base + 32'(4*DEPTH), '0, '0);
        send(1'b1, 32'h1003, 32'h1234_5678, 4'hF);
        send(1'b1, 32'h0FFC, 32'h1234_5678, 4'hF);
        send(1'b0, 32'h1000, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL err_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL err_resp[%0d]: got c=%0d d=%h e=%b, expected c=%0d d=%h e=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].e, exp_q[i].c, exp_q[i].d, exp_q[i].e);
            end
        end
        checks++;
        if (obs_q.size() < 6 || {obs_q[0].e, obs_q[2].e, obs_q[5].e, obs_q[5].d} !== {3'b110, 32'h0}) begin
            errors++; $display("FAIL err_flags: got size %0d, expected miss,miss,hit-with-zero", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mask;
        logic [31:0] want;
        want = MASK ? 32'h11BB_33DD : 32'hAABB_CCDD;
        send(1'b1, 32'h1010, 32'h1122_3344, 4'hF);
        send(1'b1, 32'h1010, 32'hAABB_CCDD, 4'b0101);
        send(1'b0, 32'h1010, '0, '0);
        send(1'b1, 32'h1014, 32'h5555_AAAA, 4'hF);
        send(1'b1, 32'h1014, 32'h0BAD_F00D, 4'h0);
        send(1'b0, 32'h1014, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL mask_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mask_resp[%0d]: got c=%0d d=%h e=%b, expected c=%0d d=%h e=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].e, exp_q[i].c, exp_q[i].d, exp_q[i].e);
            end
        end
        checks++;
        if (obs_q.size() < 3 || obs_q[2].d !== want) begin
            errors++; $display("FAIL mask_data: got %h, expected %h", obs_q.size() >= 3 ? obs_q[2].d : 'x, want);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) send(1'b1, 32'h1000 + 32'(4*i), 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) send(1'b0, 32'h1000 + 32'(4*i), '0, '0);
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (obs_q.size() != 16) begin
            errors++; $display("FAIL b2b_count: got %0d, expected 16", obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: got c=%0d d=%h e=%b, expected c=%0d d=%h e=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].e, exp_q[i].c, exp_q[i].d, exp_q[i].e);
            end
        end
        for (int i = 0; i < 8; i++) if (8 + i < obs_q.size()) begin
            checks++;
            if (obs_q[8+i].d !== 32'(i) || obs_q[8+i].c !== obs_q[0].c + 32'(8 + i)) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got d=%0d c=%0d, expected d=%0d c=%0d",
                         i, obs_q[8+i].d, obs_q[8+i].c, i, obs_q[0].c + 32'(8 + i));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        logic [31:0] addr;
        int          r;
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 75)      addr = m_base + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r < 85) addr = m_base + 32'($urandom_range(0, 4*DEPTH - 1)) | 32'h1;
            else if (r < 93) addr = m_base - 32'(4 * $urandom_range(1, 4));
            else             addr = m_base + 32'(4 * $urandom_range(DEPTH, DEPTH + 3));
            send(1'($urandom_range(0, 1)), addr, 32'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got c=%0d d=%h e=%b, expected c=%0d d=%h e=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].e, exp_q[i].c, exp_q[i].d, exp_q[i].e);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_inflight;
        send(1'b1, 32'h1008, 32'hCAFE_F00D, 4'hF);
        repeat (LAT + 2) @(negedge clk);
        obs_q.delete(); exp_q.delete();
        send(1'b0, 32'h1008, '0, '0);
        send(1'b0, 32'h1008, '0, '0);
        send(1'b0, 32'h1008, '0, '0);
        // First read is on the outputs now; the other two are still in the pipe.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_immediate: got valid=%b ready=%b, expected 0 0", resp_valid, req_ready);
        end
        exp_q = exp_q[0:0];
        ref_mem.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 32'h1008, '0, '0);
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rst_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_resp[%0d]: got c=%0d d=%h e=%b, expected c=%0d d=%h e=%b",
                         i, obs_q[i].c, obs_q[i].d, obs_q[i].e, exp_q[i].c, exp_q[i].d, exp_q[i].e);
            end
        end
        checks++;
        if (obs_q.size() != 2 || obs_q[0].d !== 32'hCAFE_F00D || obs_q[1].d !== 32'h0) begin
            errors++; $display("FAIL rst_cleared: got %0d responses, expected pre-reset cafef00d then 0", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_mask();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
